// File: rtl/proc_pkg.sv
// Shared constants for the multi-cycle processor: opcodes, instruction field
// positions and FSM state encodings.
package proc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_LDI  = 4'h4;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_OUT  = 4'hF;

    localparam int OPC_LSB = 28;
    localparam int RD_LSB  = 24;
    localparam int RS_LSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

    typedef logic [2:0] state_t;
    localparam state_t S_WAIT   = 3'd0;
    localparam state_t S_FETCH  = 3'd1;
    localparam state_t S_LOAD   = 3'd2;
    localparam state_t S_EXEC   = 3'd3;
    localparam state_t S_HALTED = 3'd4;

    function automatic logic [3:0] reg_field(input logic [31:0] word, input int lsb);
        return word[lsb +: 4];
    endfunction

endpackage

// File: rtl/proc_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// R0 and indices beyond NUM_REGS always read zero; writes to them are dropped.
module proc_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [3:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [3:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (we && (wa == 4'(i))) begin
                regs_d[i] = wd;
            end
        end
        regs_d[0] = '0;
    end

    always_comb begin
        ra_data = '0;
        rb_data = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (ra_addr == 4'(i)) ra_data = regs_q[i];
            if (rb_addr == 4'(i)) rb_data = regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/proc_core.sv
// Multi-cycle processor core; one instruction per prescaler tick.
// Define PROC_CORE_BRANCH_EN to enable BEQ/JMP (otherwise they are illegal).
//   state    | meaning
//   S_WAIT   | idle until a tick is pending and run is high
//   S_FETCH  | imem_addr=pc presented to instruction memory
//   S_LOAD   | capture imem_rdata into ir
//   S_EXEC   | read operands, compute, write back, update pc
//   S_HALTED | terminal after HALT, left only by reset
module proc_core
    import proc_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 3,
    parameter int TICK_DIV = 30000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              halted,
    output logic              illegal_op
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              rvalid_q, rvalid_d;
    logic              illegal_q, illegal_d;

    logic              tick, consume;
    logic [3:0]        opcode, rd, rs, rt;
    logic [IMM_W-1:0]  imm;
    logic signed [IMM_W-1:0] imm_s;
    logic [DATA_W-1:0] rs_val, rt_val, rf_wd;
    logic              rf_we;
    logic [ADDR_W-1:0] pc_inc;

    assign opcode = ir_q[OPC_LSB +: 4];
    assign rd     = reg_field(ir_q, RD_LSB);
    assign rs     = reg_field(ir_q, RS_LSB);
    assign rt     = reg_field(ir_q, RT_LSB);
    assign imm    = ir_q[IMM_LSB +: IMM_W];
    assign imm_s  = signed'(imm);
    assign pc_inc = pc_q + ADDR_W'(1);

    assign tick    = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign consume = (state_q == S_WAIT) && pend_q && run;

    proc_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (rs),
        .ra_data (rs_val),
        .rb_addr (rt),
        .rb_data (rt_val),
        .we      (rf_we),
        .wa      (rd),
        .wd      (rf_wd)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        result_d  = result_q;
        rvalid_d  = 1'b0;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_wd     = '0;
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        // a tick landing in the consuming cycle is kept, not lost
        pend_d    = tick | (pend_q & ~consume);

        case (state_q)
            S_WAIT:  if (consume) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                ir_d    = imem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WAIT;
                pc_d    = pc_inc;
                case (opcode)
                    OP_NOP: ;
                    OP_ADDI: begin
                        rf_we = 1'b1;
                        rf_wd = rs_val + DATA_W'(imm_s);
                    end
                    OP_ADD: begin
                        rf_we = 1'b1;
                        rf_wd = rs_val + rt_val;
                    end
                    OP_SUB: begin
                        rf_we = 1'b1;
                        rf_wd = rs_val - rt_val;
                    end
                    OP_LDI: begin
                        rf_we = 1'b1;
                        rf_wd = DATA_W'(imm);
                    end
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_HALTED;
                    end
                    OP_OUT: begin
                        result_d = rs_val;
                        rvalid_d = 1'b1;
                    end
`ifdef PROC_CORE_BRANCH_EN
                    OP_BEQ: if (rs_val == rt_val) pc_d = pc_inc + imm[ADDR_W-1:0];
                    OP_JMP: pc_d = imm[ADDR_W-1:0];
`endif
                    default: begin
                        result_d  = '1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_HALTED: ;
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT;
            pc_q      <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            ir_q      <= '0;
            result_q  <= '0;
            rvalid_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            ir_q      <= ir_d;
            result_q  <= result_d;
            rvalid_q  <= rvalid_d;
            illegal_q <= illegal_d;
        end
    end

    assign imem_addr    = pc_q;
    assign result       = result_q;
    assign result_valid = rvalid_q;
    assign halted       = (state_q == S_HALTED);
    assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_proc_core.sv
// Directed bench for proc_core: one instance with TICK_DIV=1, one with TICK_DIV=5.
// OUT results are checked through an expected-value queue.
module tb_proc_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, run_a, valid_a, halted_a, ill_a;
    logic [2:0]  addr_a;
    logic [31:0] rdata_a, result_a;
    logic        rst_b_n, run_b, valid_b, halted_b, ill_b;
    logic [2:0]  addr_b;
    logic [31:0] rdata_b, result_b;

    logic [31:0] mem_a [8];
    logic [31:0] mem_b [8];
    logic [31:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int pulses_a = 0;

    proc_core #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(3), .TICK_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .run(run_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .result(result_a), .result_valid(valid_a), .halted(halted_a), .illegal_op(ill_a));

    proc_core #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(3), .TICK_DIV(5)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .run(run_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .result(result_b), .result_valid(valid_b), .halted(halted_b), .illegal_op(ill_b));

    always @(posedge clk) rdata_a <= mem_a[addr_a];
    always @(posedge clk) rdata_b <= mem_b[addr_b];

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt,
                                        input logic [15:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_a();
        logic [31:0] e;
        @(negedge clk);
        if (valid_a) begin
            pulses_a++;
            check("sb_has_entry", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_result", result_a, e);
            end
        end
    endtask

    task automatic hold_reset_a();
        rst_a_n = 1'b0;
        @(negedge clk);
        check("rst_result", result_a, 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_halted", 32'(halted_a), 32'd0);
        check("rst_illegal", 32'(ill_a), 32'd0);
        check("rst_pc", 32'(addr_a), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) mem_a[i] = enc(4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    endtask

    task automatic run_until_halt_a(input int budget);
        for (int i = 0; i < budget && !halted_a; i++) step_a();
        check("halt_reached", 32'(halted_a), 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int exp_pc;
        int marks [$];
        logic [2:0] prev;

        rst_a_n = 1'b0; run_a = 1'b1;
        rst_b_n = 1'b0; run_b = 1'b0;
        for (int i = 0; i < 8; i++) mem_b[i] = enc(4'h0, 4'h0, 4'h0, 4'h0, 16'h0);

        // 1: basic program, 4-cycle cadence, halt freezes pc
        hold_reset_a();
        mem_a[0] = enc(4'h4, 4'd1, 4'd0, 4'd0, 16'd5);
        mem_a[1] = enc(4'h1, 4'd2, 4'd1, 4'd0, 16'hFFFE);
        mem_a[2] = enc(4'h2, 4'd3, 4'd1, 4'd2, 16'd0);
        mem_a[3] = enc(4'hF, 4'd0, 4'd3, 4'd0, 16'd0);
        mem_a[4] = enc(4'hE, 4'd0, 4'd0, 4'd0, 16'd0);
        exp_q.push_back(32'd8);
        p0 = pulses_a;
        rst_a_n = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            step_a();
            exp_pc = (n < 5) ? 0 : (((n - 1) / 4 > 4) ? 4 : (n - 1) / 4);
            check("t1_pc", 32'(addr_a), 32'(exp_pc));
            check("t1_valid", 32'(valid_a), 32'(n == 17));
            check("t1_halted", 32'(halted_a), 32'(n >= 21));
        end
        check("t1_result", result_a, 32'd8);
        check("t1_pulses", 32'(pulses_a - p0), 32'd1);
        check("t1_sb_drained", 32'(exp_q.size()), 32'd0);

        // 2: subtract/decrement wraps to all ones, legal ops only
        hold_reset_a();
        mem_a[0] = enc(4'h3, 4'd1, 4'd0, 4'd0, 16'd0);
        mem_a[1] = enc(4'h1, 4'd1, 4'd1, 4'd0, 16'hFFFF);
        mem_a[2] = enc(4'hF, 4'd0, 4'd1, 4'd0, 16'd0);
        mem_a[3] = enc(4'hE, 4'd0, 4'd0, 4'd0, 16'd0);
        exp_q.push_back(32'hFFFF_FFFF);
        rst_a_n = 1'b1;
        run_until_halt_a(40);
        check("t2_illegal", 32'(ill_a), 32'd0);

        // 3: pc wrap over eight words, illegal opcode at address 3
        hold_reset_a();
        mem_a[3] = enc(4'h7, 4'd0, 4'd0, 4'd0, 16'd0);
        p0 = pulses_a;
        rst_a_n = 1'b1;
        prev = addr_a;
        check("t3_pc_start", 32'(addr_a), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            for (int c = 0; c < 10 && addr_a == prev; c++) step_a();
            check("t3_pc", 32'(addr_a), 32'(k % 8));
            if (k == 3) check("t3_ill_before", 32'(ill_a), 32'd0);
            if (k == 4) begin
                check("t3_ill_after", 32'(ill_a), 32'd1);
                check("t3_result", result_a, 32'hFFFF_FFFF);
            end
            prev = addr_a;
        end
        check("t3_no_pulse", 32'(pulses_a - p0), 32'd0);

        // 5: async reset during EXEC of ADD r3 aborts it and clears registers
        hold_reset_a();
        mem_a[0] = enc(4'h4, 4'd3, 4'd0, 4'd0, 16'd7);
        mem_a[1] = enc(4'hF, 4'd0, 4'd3, 4'd0, 16'd0);
        mem_a[2] = enc(4'h2, 4'd3, 4'd3, 4'd3, 16'd0);
        exp_q.push_back(32'd7);
        rst_a_n = 1'b1;
        repeat (12) step_a();
        check("t5_sb_seven", 32'(exp_q.size()), 32'd0);
        rst_a_n = 1'b0;
        #1;
        check("t5_rst_result", result_a, 32'd0);
        check("t5_rst_valid", 32'(valid_a), 32'd0);
        check("t5_rst_halted", 32'(halted_a), 32'd0);
        check("t5_rst_illegal", 32'(ill_a), 32'd0);
        check("t5_rst_pc", 32'(addr_a), 32'd0);
        for (int i = 0; i < 8; i++) mem_a[i] = enc(4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
        mem_a[0] = enc(4'hF, 4'd0, 4'd3, 4'd0, 16'd0);
        mem_a[1] = enc(4'hE, 4'd0, 4'd0, 4'd0, 16'd0);
        exp_q.push_back(32'd0);
        @(negedge clk);
        rst_a_n = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step_a();
            if (n == 4) check("t5_pc_hold", 32'(addr_a), 32'd0);
            if (n == 5) check("t5_pc_restart", 32'(addr_a), 32'd1);
        end
        run_until_halt_a(20);

        // 6: BEQ r0,r0,-1 at address 2
        hold_reset_a();
        mem_a[2] = enc(4'h8, 4'd0, 4'd0, 4'd0, 16'hFFFF);
        rst_a_n = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            step_a();
            if (n == 9) check("t6_pc_at2", 32'(addr_a), 32'd2);
`ifdef PROC_CORE_BRANCH_EN
            if (n == 13 || n == 17 || n == 21) check("t6_pc_loop", 32'(addr_a), 32'd2);
`else
            if (n == 13 || n == 17 || n == 21) check("t6_pc_adv", 32'(addr_a), 32'((n - 9) / 4 + 2));
`endif
        end
`ifdef PROC_CORE_BRANCH_EN
        check("t6_illegal", 32'(ill_a), 32'd0);
`else
        check("t6_illegal", 32'(ill_a), 32'd1);
        check("t6_result", result_a, 32'hFFFF_FFFF);
`endif
        rst_a_n = 1'b0;

        // 4: TICK_DIV=5, paused then released; merged tick, then 5-cycle spacing
        @(negedge clk);
        check("t4_rst_pc", 32'(addr_b), 32'd0);
        check("t4_rst_halted", 32'(halted_b), 32'd0);
        check("t4_rst_result", result_b, 32'd0);
        rst_b_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("t4_idle_pc", 32'(addr_b), 32'd0);
        end
        run_b = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk);
            check("t4_first_instr", 32'(addr_b), 32'(s == 4));
        end
        prev = addr_b;
        for (int c = 0; c < 30 && marks.size() < 3; c++) begin
            @(negedge clk);
            if (addr_b != prev) begin
                marks.push_back(c);
                prev = addr_b;
            end
        end
        check("t4_fetch_count", 32'(marks.size()), 32'd3);
        if (marks.size() == 3) begin
            check("t4_spacing_a", 32'(marks[1] - marks[0]), 32'd5);
            check("t4_spacing_b", 32'(marks[2] - marks[1]), 32'd5);
        end
        check("t4_valid", 32'(valid_b), 32'd0);
        check("t4_illegal", 32'(ill_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
